// File: rtl/jt12_timers_if.sv
// Host-side bundle for the JT12 timer block: reload values, run/IRQ enables,
// flag clears, and the flag/IRQ/sync outputs back to the register interface.
interface jt12_timers_if;
    logic [9:0] value_A;
    logic [7:0] value_B;
    logic       load_A;
    logic       load_B;
    logic       en_irq_A;
    logic       en_irq_B;
    logic       clr_flag_A;
    logic       clr_flag_B;
    logic       zero;
    logic       flag_A;
    logic       flag_B;
    logic       overflow_A;
    logic       irq_n;

    modport master (
        output value_A, value_B, load_A, load_B, en_irq_A, en_irq_B,
               clr_flag_A, clr_flag_B,
        input  zero, flag_A, flag_B, overflow_A, irq_n
    );

    modport slave (
        input  value_A, value_B, load_A, load_B, en_irq_A, en_irq_B,
               clr_flag_A, clr_flag_B,
        output zero, flag_A, flag_B, overflow_A, irq_n
    );
endinterface

// File: rtl/jt12_timers.sv
// YM2612 Timer A (10 bit) / Timer B (8 bit) with flags, IRQ and slot-sweep pulse.
// Define JT12_CSM_EN to drive overflow_A (CSM key-on trigger); otherwise it is tied low.
module jt12_timers #(
    parameter int SLOTS = 24,
    parameter int B_DIV = 16
) (
    input  logic              clk,
    input  logic              rst,
    jt12_timers_if.slave      bus
);
    localparam logic [4:0] SLOT_LAST = 5'(SLOTS - 1);
    localparam logic [3:0] PRE_LAST  = 4'(B_DIV - 1);

    logic [4:0] slot_q, slot_d;
    logic [3:0] presc_q, presc_d;
    logic [9:0] cnt_A_q, cnt_A_d;
    logic [7:0] cnt_B_q, cnt_B_d;
    logic       load_A_q, load_B_q;
    logic       flag_A_q, flag_A_d;
    logic       flag_B_q, flag_B_d;
    logic       irq_n_q;
    logic       tick_A, tick_B;
    logic       ov_A, ov_B;

    // zero is decoded straight from the slot counter so the tick lands on the wrap edge
    assign tick_A = (slot_q == SLOT_LAST);
    assign tick_B = tick_A && (presc_q == PRE_LAST);

    always_comb begin
        slot_d  = (slot_q == SLOT_LAST) ? 5'd0 : slot_q + 5'd1;
        presc_d = presc_q;
        if (tick_A) begin
            presc_d = (presc_q == PRE_LAST) ? 4'd0 : presc_q + 4'd1;
        end

        ov_A    = 1'b0;
        cnt_A_d = cnt_A_q;
        if (bus.load_A && !load_A_q) begin
            cnt_A_d = bus.value_A;
        end else if (bus.load_A && tick_A) begin
            if (&cnt_A_q) begin
                cnt_A_d = bus.value_A;
                ov_A    = 1'b1;
            end else begin
                cnt_A_d = cnt_A_q + 10'd1;
            end
        end

        ov_B    = 1'b0;
        cnt_B_d = cnt_B_q;
        if (bus.load_B && !load_B_q) begin
            cnt_B_d = bus.value_B;
        end else if (bus.load_B && tick_B) begin
            if (&cnt_B_q) begin
                cnt_B_d = bus.value_B;
                ov_B    = 1'b1;
            end else begin
                cnt_B_d = cnt_B_q + 8'd1;
            end
        end

        // a set in the same cycle as a clear wins
        flag_A_d = (ov_A && bus.en_irq_A) ? 1'b1 :
                   (bus.clr_flag_A ? 1'b0 : flag_A_q);
        flag_B_d = (ov_B && bus.en_irq_B) ? 1'b1 :
                   (bus.clr_flag_B ? 1'b0 : flag_B_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q   <= 5'd0;
            presc_q  <= 4'd0;
            cnt_A_q  <= 10'd0;
            cnt_B_q  <= 8'd0;
            load_A_q <= 1'b0;
            load_B_q <= 1'b0;
            flag_A_q <= 1'b0;
            flag_B_q <= 1'b0;
            irq_n_q  <= 1'b1;
        end else begin
            slot_q   <= slot_d;
            presc_q  <= presc_d;
            cnt_A_q  <= cnt_A_d;
            cnt_B_q  <= cnt_B_d;
            load_A_q <= bus.load_A;
            load_B_q <= bus.load_B;
            flag_A_q <= flag_A_d;
            flag_B_q <= flag_B_d;
            irq_n_q  <= ~(flag_A_q | flag_B_q);
        end
    end

`ifdef JT12_CSM_EN
    logic ov_A_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ov_A_q <= 1'b0;
        end else begin
            ov_A_q <= ov_A;
        end
    end

    assign bus.overflow_A = ov_A_q;
`else
    assign bus.overflow_A = 1'b0;
`endif

    assign bus.zero   = tick_A;
    assign bus.flag_A = flag_A_q;
    assign bus.flag_B = flag_B_q;
    assign bus.irq_n  = irq_n_q;
endmodule

// File: doc/jt12_timers.md
# jt12_timers

YM2612-compatible timer block: 10-bit Timer A and 8-bit Timer B with overflow flags, IRQ generation and a slot-sweep sync pulse. Sits directly downstream of the JT12 clock/reset generator: clocked by its divided internal clock and reset by its synchronised internal reset. Feeds the register interface (status flags), the host IRQ line and the key-on logic (CSM).

## Interface

Parameters:
- SLOTS, 24, internal clocks per slot sweep (Timer A tick period)
- B_DIV, 16, Timer A ticks per Timer B tick

Ports:
- clk  in  1  internal chip clock (divided clock from the clock generator); single clock domain
- rst  in  1  synchronous, active-high reset (internal reset from the clock generator)
- value_A  in  10  Timer A reload value
- value_B  in  8  Timer B reload value
- load_A  in  1  Timer A run enable; rising edge loads the counter
- load_B  in  1  Timer B run enable; rising edge loads the counter
- en_irq_A  in  1  allow Timer A overflow to set flag_A
- en_irq_B  in  1  allow Timer B overflow to set flag_B
- clr_flag_A  in  1  one-cycle pulse, clears flag_A
- clr_flag_B  in  1  one-cycle pulse, clears flag_B
- zero  out  1  one-cycle pulse at slot-counter wrap (Timer A tick)
- flag_A  out  1  Timer A overflow flag
- flag_B  out  1  Timer B overflow flag
- overflow_A  out  1  one-cycle pulse on every Timer A overflow (CSM trigger)
- irq_n  out  1  active-low interrupt request

## Operation

- Slot counter: 5-bit, 0..SLOTS-1, increments every clk, wraps to 0; zero=1 on the cycle it holds SLOTS-1.
- Timer A tick = zero. B prescaler: 4-bit, increments on each Timer A tick; Timer B tick = A tick with prescaler at B_DIV-1. Prescaler runs regardless of load_B.
- Per timer (A: 10 bit, B: 8 bit), priority high→low:
  - load rising edge (registered previous load): counter ← value.
  - load=0: counter holds.
  - load=1 and tick: counter at all-ones → overflow: counter ← value, overflow event; else counter+1.
- Overflow event: flag ← 1 only if en_irq set; overflow_A pulses regardless of en_irq_A.
- Flags: clr_flag pulse clears; simultaneous set and clear → set wins.
- irq_n registered: ~(flag_A | flag_B).
- Period A = (1024−value_A)·SLOTS clk; period B = (256−value_B)·B_DIV·SLOTS clk.
- value changes while running take effect only at next load edge or overflow.

## Timing

- Reset values: slot counter 0, prescaler 0, counters 0, zero 0, flag_A 0, flag_B 0, overflow_A 0, irq_n 1, registered load history 0.
- rst is sampled on clk; asserting it mid-count aborts everything to reset values the next edge; load held high through reset release counts as a new rising edge on the first post-reset cycle.
- Counter load: 1 clk after load edge. Flag and overflow_A: asserted on the edge that processes the overflowing tick. irq_n: 1 clk after flag change.
- Overflow at tick with load falling on the same cycle: load=0 takes priority, no overflow.

## Configuration

- JT12_CSM_EN defined: overflow_A driven as specified.
- Not defined: overflow_A tied to 0, its logic removed; flags and IRQ unaffected.

## Test plan

- Reset: hold rst 3 cycles with all inputs active → outputs at reset values, irq_n=1; zero first pulses 24 clk after release.
- value_A=1023, load_A↑, en_irq_A=1 → overflow every 24 clk; flag_A=1 at first overflow, irq_n=0 one clk later.
- value_A=1000, en_irq_A=0 → flag_A stays 0, overflow_A pulses every 576 clk (JT12_CSM_EN), irq_n stays 1.
- value_B=255, load_B↑, en_irq_B=1 → flag_B sets after ≤384 clk, then every 384 clk; clr_flag_B clears, irq_n=1 next clk.
- clr_flag_A on same cycle as Timer A overflow → flag_A=1.
- load_A dropped mid-count, raised 100 clk later with value_A=1020 → counter holds, then reloads 1020; overflow 96 clk after reload (4 ticks, tick-aligned).
